// File: rtl/onfi_cmd_addr_seq.sv
// onfi_cmd_addr_seq: ONFI SDR command/address sequencer. One request drives
// CMD0, 0-5 address cycles, optional CMD1 and an optional ready/busy wait.
// Ports: clk, rst_n (async low); req_* request bundle with req_ready;
// done/timeout/busy status; CE_x_n, CLE_x, ALE_x, WE_x_n, RE_x_n, io_out,
// io_oe NAND pins; rb_x_n asynchronous ready/busy input.
// Build option: define ONFI_RB_WAIT_EN to add the tWB + R/B wait phases.
module onfi_cmd_addr_seq #(
  parameter int TWP_CYC  = 2,
  parameter int TWH_CYC  = 2,
  parameter int TCS_CYC  = 1,
  parameter int TWB_CYC  = 4,
  parameter int TOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_cmd0,
  input  logic [2:0]  req_addr_cnt,
  input  logic [39:0] req_addr,
  input  logic        req_has_cmd1,
  input  logic [7:0]  req_cmd1,
  output logic        done,
  output logic        timeout,
  output logic        busy,
  output logic        CE_x_n,
  output logic        CLE_x,
  output logic        ALE_x,
  output logic        WE_x_n,
  output logic        RE_x_n,
  output logic [7:0]  io_out,
  output logic        io_oe,
  input  logic        rb_x_n
);

  typedef enum logic [2:0] {
    IDLE, CE_SETUP, CMD0, ADDR,
    CMD1, WB_WAIT, RB_WAIT, DONE
  } state_t;

  localparam logic [15:0] TCS_LAST =
    16'(TCS_CYC - 1);
  localparam logic [15:0] WR_LAST =
    16'(TWP_CYC + TWH_CYC - 1);
  localparam logic [15:0] TWP_N =
    16'(TWP_CYC);

`ifdef ONFI_RB_WAIT_EN
  localparam int RW = $clog2(TOUT_CYC + 1);
  localparam logic [15:0] TWB_LAST =
    16'(TWB_CYC - 1);
  localparam logic [RW-1:0] TOUT_LAST =
    RW'(TOUT_CYC - 1);
`else
  localparam int unused_cfg =
    TWB_CYC + TOUT_CYC;
`endif

  state_t      state, nxt;
  logic [15:0] cnt, cnt_d;
  logic [2:0]  idx, idx_d;
  logic        lat;

  logic [7:0]  cmd0_q, cmd1_q;
  logic [39:0] addr_q;
  logic [2:0]  acnt_q;
  logic        has1_q;
  logic [2:0]  acnt_c;

  logic        ce_d, cle_d, ale_d, we_d;
  logic [7:0]  io_d, byte_d;
  logic        oe_d, done_d, tmo_d;
  logic        rdy_d, busy_d;
  logic        bus_d;
  state_t      post;

`ifdef ONFI_RB_WAIT_EN
  logic          rb_s1, rb_s2;
  logic [RW-1:0] rb_cnt, rbc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_s1  <= 1'b0;
      rb_s2  <= 1'b0;
      rb_cnt <= '0;
    end else begin
      rb_s1  <= rb_x_n;
      rb_s2  <= rb_s1;
      rb_cnt <= rbc_d;
    end
  end
`else
  logic unused_rb;
  assign unused_rb = rb_x_n;
`endif

  assign acnt_c = (req_addr_cnt > 3'd5)
                ? 3'd5 : req_addr_cnt;

`ifdef ONFI_RB_WAIT_EN
  assign post = WB_WAIT;
`else
  assign post = DONE;
`endif

  always_comb begin
    nxt   = state;
    cnt_d = cnt;
    idx_d = idx;
    lat   = 1'b0;
    tmo_d = 1'b0;
`ifdef ONFI_RB_WAIT_EN
    rbc_d = rb_cnt;
`endif
    unique case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          lat   = 1'b1;
          nxt   = CE_SETUP;
          cnt_d = '0;
        end
      end
      CE_SETUP: begin
        if (cnt == TCS_LAST) begin
          nxt   = CMD0;
          cnt_d = '0;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      CMD0, ADDR, CMD1: begin
        if (cnt != WR_LAST) begin
          cnt_d = cnt + 16'd1;
        end else begin
          cnt_d = '0;
          if (state == CMD0 && acnt_q != 3'd0) begin
            nxt   = ADDR;
            idx_d = 3'd0;
          end else if (state == ADDR &&
                       idx != 3'(acnt_q - 3'd1)) begin
            idx_d = idx + 3'd1;
          end else if (state != CMD1 && has1_q) begin
            nxt = CMD1;
          end else begin
            nxt = post;
          end
        end
      end
`ifdef ONFI_RB_WAIT_EN
      WB_WAIT: begin
        if (cnt == TWB_LAST) begin
          nxt   = RB_WAIT;
          cnt_d = '0;
          rbc_d = '0;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      RB_WAIT: begin
        // The entry-cycle sample is ignored so a stale
        // ready level cannot end the wait early.
        if (rb_s2 && rb_cnt != '0) begin
          nxt = DONE;
        end else if (rb_cnt == TOUT_LAST) begin
          nxt   = DONE;
          tmo_d = 1'b1;
        end else begin
          rbc_d = rb_cnt + RW'(1);
        end
      end
`else
      WB_WAIT, RB_WAIT: nxt = DONE;
`endif
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    byte_d = 8'h00;
    case (idx_d)
      3'd0: byte_d = addr_q[7:0];
      3'd1: byte_d = addr_q[15:8];
      3'd2: byte_d = addr_q[23:16];
      3'd3: byte_d = addr_q[31:24];
      3'd4: byte_d = addr_q[39:32];
      default: byte_d = 8'h00;
    endcase
  end

  // Pin values are decoded from the next state so
  // every pin comes straight off a flop.
  always_comb begin
    bus_d  = 1'b0;
    cle_d  = 1'b0;
    ale_d  = 1'b0;
    io_d   = 8'h00;
    unique case (1'b1)
      (nxt == CMD0): begin
        bus_d = 1'b1;
        cle_d = 1'b1;
        io_d  = cmd0_q;
      end
      (nxt == ADDR): begin
        bus_d = 1'b1;
        ale_d = 1'b1;
        io_d  = byte_d;
      end
      (nxt == CMD1): begin
        bus_d = 1'b1;
        cle_d = 1'b1;
        io_d  = cmd1_q;
      end
      default: ;
    endcase
    oe_d   = bus_d;
    we_d   = !(bus_d && cnt_d < TWP_N);
    ce_d   = (nxt == IDLE) || (nxt == DONE);
    done_d = (nxt == DONE);
    rdy_d  = (nxt == IDLE);
    busy_d = (nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      cmd0_q <= '0;
      cmd1_q <= '0;
      addr_q <= '0;
      acnt_q <= '0;
      has1_q <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= cnt_d;
      idx   <= idx_d;
      if (lat) begin
        cmd0_q <= req_cmd0;
        cmd1_q <= req_cmd1;
        addr_q <= req_addr;
        acnt_q <= acnt_c;
        has1_q <= req_has_cmd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      CE_x_n    <= 1'b1;
      CLE_x     <= 1'b0;
      ALE_x     <= 1'b0;
      WE_x_n    <= 1'b1;
      RE_x_n    <= 1'b1;
      io_out    <= 8'h00;
      io_oe     <= 1'b0;
      req_ready <= 1'b1;
      done      <= 1'b0;
      timeout   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      CE_x_n    <= ce_d;
      CLE_x     <= cle_d;
      ALE_x     <= ale_d;
      WE_x_n    <= we_d;
      RE_x_n    <= 1'b1;
      io_out    <= io_d;
      io_oe     <= oe_d;
      req_ready <= rdy_d;
      done      <= done_d;
      timeout   <= tmo_d;
      busy      <= busy_d;
    end
  end

endmodule
